// File: rtl/sentinel_match_bank_pkg.sv
// Shared constants and helpers for the sentinel match bank and its entries.
package sentinel_match_bank_pkg;

  // Widest data word any instance is expected to use; ZERO_WORD is sliced down.
  localparam int MAX_WORD_WIDTH = 256;
  localparam logic [MAX_WORD_WIDTH-1:0] ZERO_WORD = {MAX_WORD_WIDTH{1'b0}};

  // Entry mode: continuous entries keep matching, one-shot entries disarm on hit.
  typedef enum logic {
    MODE_CONTINUOUS = 1'b0,
    MODE_ONE_SHOT   = 1'b1
  } entry_mode_e;

  // Entry index width: clog2 of the entry count, never below one bit.
  function automatic int entry_addr_width(input int count);
    int w;
    w = $clog2(count);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/sentinel_match_bank_entry.sv
// One programmable sentinel/mask comparator with its configuration registers.
module sentinel_match_entry
  import sentinel_match_bank_pkg::*;
#(
  parameter int WORD_WIDTH       = 36,
  parameter int ENTRY_ADDR_WIDTH = 2,
  parameter int ENTRY_INDEX      = 0
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [ENTRY_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0]       wr_sentinel,
  input  logic [WORD_WIDTH-1:0]       wr_mask,
  input  logic                        wr_one_shot,
  input  logic [WORD_WIDTH-1:0]       data_in,
  input  logic                        data_in_valid,
  output logic                        hit
);

  localparam logic [ENTRY_ADDR_WIDTH-1:0] MY_ADDR = ENTRY_ADDR_WIDTH'(ENTRY_INDEX);
  localparam logic [WORD_WIDTH-1:0]       ZERO    = ZERO_WORD[WORD_WIDTH-1:0];

  logic [WORD_WIDTH-1:0] sentinel_masked_q, sentinel_masked_d;
  logic [WORD_WIDTH-1:0] mask_q, mask_d;
  entry_mode_e           one_shot_q, one_shot_d;
  logic                  armed_q, armed_d;
  logic                  wr_sel_s;

  // The sentinel is stored pre-masked so the compare only masks the data side.
  assign hit = armed_q & data_in_valid & ((data_in & ~mask_q) == sentinel_masked_q);

  // Write decode and next-state; a write re-arms even if a one-shot hit fires this cycle.
  always_comb begin
    sentinel_masked_d = sentinel_masked_q;
    mask_d            = mask_q;
    one_shot_d        = one_shot_q;
    armed_d           = armed_q;
    wr_sel_s          = wr_en & (wr_addr == MY_ADDR);
    if (wr_sel_s) begin
      sentinel_masked_d = wr_sentinel & ~wr_mask;
      mask_d            = wr_mask;
      one_shot_d        = entry_mode_e'(wr_one_shot);
      armed_d           = 1'b1;
    end else if (hit && (one_shot_q == MODE_ONE_SHOT)) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
  end

  // Configuration and arm state registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      sentinel_masked_q <= ZERO;
      mask_q            <= ZERO;
      one_shot_q        <= MODE_CONTINUOUS;
      armed_q           <= 1'b0;
    end else begin
      sentinel_masked_q <= sentinel_masked_d;
      mask_q            <= mask_d;
      one_shot_q        <= one_shot_d;
      armed_q           <= armed_d;
    end
  end

endmodule

// File: rtl/sentinel_match_bank.sv
// Bank of sentinel/mask comparators with registered match vector, any flag and index.
module sentinel_match_bank
  import sentinel_match_bank_pkg::*;
#(
  parameter int WORD_WIDTH       = 36,
  parameter int ENTRY_COUNT      = 4,
  parameter int ENTRY_ADDR_WIDTH = entry_addr_width(ENTRY_COUNT)
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [ENTRY_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0]       wr_sentinel,
  input  logic [WORD_WIDTH-1:0]       wr_mask,
  input  logic                        wr_one_shot,
  input  logic [WORD_WIDTH-1:0]       data_in,
  input  logic                        data_in_valid,
  output logic [ENTRY_COUNT-1:0]      match,
  output logic                        match_any,
  output logic [ENTRY_ADDR_WIDTH-1:0] match_index,
  output logic                        match_valid
);

  logic [ENTRY_COUNT-1:0]      hit_s;
  logic [ENTRY_COUNT-1:0]      match_q, match_d;
  logic                        match_any_q, match_any_d;
  logic [ENTRY_ADDR_WIDTH-1:0] match_index_q, match_index_d;
  logic                        match_valid_q, match_valid_d;

  // Entries exist only for indices below ENTRY_COUNT, so out-of-range writes hit nothing.
  for (genvar e = 0; e < ENTRY_COUNT; e++) begin : g_entry
    sentinel_match_entry #(
      .WORD_WIDTH       (WORD_WIDTH),
      .ENTRY_ADDR_WIDTH (ENTRY_ADDR_WIDTH),
      .ENTRY_INDEX      (e)
    ) u_entry (
      .clock         (clock),
      .clear         (clear),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_sentinel   (wr_sentinel),
      .wr_mask       (wr_mask),
      .wr_one_shot   (wr_one_shot),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .hit           (hit_s[e])
    );
  end

  // Next result: hit vector, OR-reduce and lowest-index priority encode (scan high to low).
  always_comb begin
    match_d       = hit_s;
    match_any_d   = |hit_s;
    match_valid_d = data_in_valid;
    match_index_d = {ENTRY_ADDR_WIDTH{1'b0}};
    for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        match_index_d = ENTRY_ADDR_WIDTH'(i);
      end else begin
        match_index_d = match_index_d;
      end
    end
  end

  // Output registers; clear discards any pending result.
  always_ff @(posedge clock) begin
    if (clear) begin
      match_q       <= {ENTRY_COUNT{1'b0}};
      match_any_q   <= 1'b0;
      match_index_q <= {ENTRY_ADDR_WIDTH{1'b0}};
      match_valid_q <= 1'b0;
    end else begin
      match_q       <= match_d;
      match_any_q   <= match_any_d;
      match_index_q <= match_index_d;
      match_valid_q <= match_valid_d;
    end
  end

  assign match       = match_q;
  assign match_any   = match_any_q;
  assign match_index = match_index_q;
  assign match_valid = match_valid_q;

endmodule

// File: tb/tb_sentinel_match_bank.sv
// Directed vector table plus randomized traffic against a reference model.
module tb_sentinel_match_bank;

  localparam int W  = 36;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          clear, wr_en, wr_one_shot, data_in_valid;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_sentinel, wr_mask, data_in;
  logic [N-1:0]  match;
  logic          match_any, match_valid;
  logic [AW-1:0] match_index;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: per-entry masked sentinel, mask, mode and arm flag.
  logic [W-1:0] m_sent  [N];
  logic [W-1:0] m_mask  [N];
  bit           m_os    [N];
  bit           m_armed [N];

  typedef struct {
    bit          clr, we, os, valid, ev;
    int          addr, ei;
    logic [W-1:0] sent, mask, data;
    logic [N-1:0] em;
  } vec_t;
  vec_t vecs[$];

  sentinel_match_bank #(.WORD_WIDTH(W), .ENTRY_COUNT(N), .ENTRY_ADDR_WIDTH(AW)) dut (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_sentinel(wr_sentinel), .wr_mask(wr_mask), .wr_one_shot(wr_one_shot),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .match(match), .match_any(match_any), .match_index(match_index),
    .match_valid(match_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input bit clr, input bit we, input int addr, input logic [W-1:0] sent,
                     input logic [W-1:0] mask, input bit os, input logic [W-1:0] data,
                     input bit valid, input logic [N-1:0] em, input int ei, input bit ev);
    vec_t v;
    v.clr = clr; v.we = we; v.addr = addr; v.sent = sent; v.mask = mask; v.os = os;
    v.data = data; v.valid = valid; v.em = em; v.ei = ei; v.ev = ev;
    vecs.push_back(v);
  endtask

  // Drive one cycle, predict from the model, advance model, compare after the edge.
  task automatic step(input bit clr, input bit we, input int addr, input logic [W-1:0] sent,
                      input logic [W-1:0] mask, input bit os, input logic [W-1:0] data,
                      input bit valid, input bit use_tbl, input logic [N-1:0] tm,
                      input int ti, input bit tv);
    logic [N-1:0] em;
    int ei;
    bit found;
    clear = clr; wr_en = we; wr_addr = AW'(addr); wr_sentinel = sent; wr_mask = mask;
    wr_one_shot = os; data_in = data; data_in_valid = valid;
    em = '0; ei = 0; found = 0;
    for (int e = 0; e < N; e++) begin
      if (m_armed[e] && valid && ((data & ~m_mask[e]) == m_sent[e])) begin
        em[e] = 1'b1;
        if (!found) begin ei = e; found = 1; end
      end
    end
    if (clr) begin
      em = '0; ei = 0;
      for (int e = 0; e < N; e++) begin
        m_sent[e] = '0; m_mask[e] = '0; m_os[e] = 0; m_armed[e] = 0;
      end
    end else begin
      for (int e = 0; e < N; e++) if (em[e] && m_os[e]) m_armed[e] = 0;
      if (we && addr < N) begin
        m_sent[addr] = sent & ~mask; m_mask[addr] = mask; m_os[addr] = os; m_armed[addr] = 1;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    check("match", 64'(match), 64'(em));
    check("match_any", 64'(match_any), 64'(|em));
    check("match_index", 64'(match_index), 64'(ei));
    check("match_valid", 64'(match_valid), 64'(valid && !clr));
    if (use_tbl) begin
      check("tbl_match", 64'(match), 64'(tm));
      check("tbl_index", 64'(match_index), 64'(ti));
      check("tbl_valid", 64'(match_valid), 64'(tv));
    end
  endtask

  initial begin
    logic [W-1:0] d, s, mk;
    int e;
    for (int i = 0; i < N; i++) begin
      m_sent[i] = '0; m_mask[i] = '0; m_os[i] = 0; m_armed[i] = 0;
    end
    clear = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_sentinel = '0; wr_mask = '0;
    wr_one_shot = 1'b0; data_in = '0; data_in_valid = 1'b0;
    #1;

    //  clr we a  sentinel         mask             os data             v  exp   idx ev
    add(1, 0, 0, 36'h0,           36'h0,           0, 36'h0,           0, 4'b0000, 0, 0);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0,           1, 4'b0000, 0, 1);
    add(0, 1, 2, 36'h0_0000_00AB, 36'h0,           0, 36'h0,           0, 4'b0000, 0, 0);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_00AB, 1, 4'b0100, 2, 1);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_00AC, 1, 4'b0000, 0, 1);
    add(0, 1, 0, 36'h0_0000_0012, 36'hF_FFFF_FF00, 0, 36'h0,           0, 4'b0000, 0, 0);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h5_5555_5512, 1, 4'b0001, 0, 1);
    add(0, 1, 0, 36'h0_0000_00AB, 36'hF_FFFF_FF00, 0, 36'h0,           0, 4'b0000, 0, 0);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_00AB, 1, 4'b0101, 0, 1);
    add(0, 1, 1, 36'h0_0000_0007, 36'h0,           1, 36'h0,           0, 4'b0000, 0, 0);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_0007, 1, 4'b0010, 1, 1);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_0007, 1, 4'b0000, 0, 1);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_0007, 1, 4'b0000, 0, 1);
    add(0, 1, 1, 36'h0_0000_0007, 36'h0,           1, 36'h0,           0, 4'b0000, 0, 0);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_0007, 1, 4'b0010, 1, 1);
    add(0, 1, 3, 36'h0_0000_0009, 36'h0,           0, 36'h0_0000_0009, 1, 4'b0000, 0, 1);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_0009, 1, 4'b1000, 3, 1);
    add(0, 1, 1, 36'h0_0000_0007, 36'h0,           1, 36'h0,           0, 4'b0000, 0, 0);
    add(0, 1, 1, 36'h0_0000_0007, 36'h0,           1, 36'h0_0000_0007, 1, 4'b0010, 1, 1);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_0007, 1, 4'b0010, 1, 1);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_0007, 1, 4'b0000, 0, 1);
    add(0, 1, 3, 36'h0_0000_0009, 36'hF_FFFF_FFFF, 0, 36'h0,           0, 4'b0000, 0, 0);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h1_2345_6789, 1, 4'b1000, 3, 1);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_0007, 0, 4'b0000, 0, 0);
    add(0, 1, 1, 36'h0_0000_0007, 36'h0,           1, 36'h0,           0, 4'b0000, 0, 0);
    add(1, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_0007, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'h0_0000_0007, 1, 4'b0000, 0, 1);
    add(0, 0, 0, 36'h0,           36'h0,           0, 36'hF_FFFF_FFFF, 1, 4'b0000, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].we, vecs[i].addr, vecs[i].sent, vecs[i].mask, vecs[i].os,
           vecs[i].data, vecs[i].valid, 1'b1, vecs[i].em, vecs[i].ei, vecs[i].ev);
    end

    // Randomized traffic: data is often built from a stored sentinel to provoke hits.
    for (int n = 0; n < 600; n++) begin
      e = $urandom_range(0, N - 1);
      s = {4'($urandom), 32'($urandom)};
      case ($urandom_range(0, 3))
        0: mk = '0;
        1: mk = '1;
        2: mk = 36'hF_FFFF_FF00;
        default: mk = {4'($urandom), 32'($urandom)};
      endcase
      if ($urandom_range(0, 2) != 0)
        d = m_sent[e] | ({4'($urandom), 32'($urandom)} & m_mask[e]);
      else
        d = {4'($urandom), 32'($urandom)};
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, N - 1),
           s, mk, 1'($urandom), d, $urandom_range(0, 4) != 0, 1'b0, '0, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
